// File: rtl/custom_unfold_ram.sv
// custom_unfold_ram: bit-unfold stage between the 32-bit sample-word RAM and
// the I/Q mapping path. Captures a word at index 0 and emits one bit per
// addressed read as a signed antipodal DAC level (+AMP for 1, -AMP for 0).
// The parent owns all sequencing; this block has no counters.
//
// Build option: define UNFOLD_MSB_FIRST_EN to emit bits MSB first
// (index 0 -> bit DATA_W-1). Default build is LSB first.
module custom_unfold_ram #(
  parameter int unsigned           DATA_W = 32,
  parameter int unsigned           ADDR_W = 5,
  parameter int unsigned           OUT_W  = 16,
  parameter logic [OUT_W-1:0]      AMP    = 16'h3FFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ena,
  input  logic [DATA_W-1:0] axis_data,
  input  logic [ADDR_W-1:0] ADD_R,
  output logic [OUT_W-1:0]  axis_unfold_data
);

  // Two's-complement negative level, computed in OUT_W bits.
  localparam logic [OUT_W-1:0] NEG_AMP = ~AMP + 1'b1;

  logic [DATA_W-1:0] word_q;
  logic [ADDR_W-1:0] idx;
  logic              capture;
  logic              bit_sel;

  // Map the parent's index onto a bit position and pick the source word;
  // index 0 bypasses word_q so the new word is visible on the capture edge.
  always_comb begin
    capture = (ADD_R == '0);
`ifdef UNFOLD_MSB_FIRST_EN
    idx = ADDR_W'(DATA_W - 1) - ADD_R;
`else
    idx = ADD_R;
`endif
    bit_sel = capture ? axis_data[idx] : word_q[idx];
  end

  // Word capture and registered antipodal output; reset wins over ena.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q           <= '0;
      axis_unfold_data <= '0;
    end else if (ena) begin
      if (capture) begin
        word_q <= axis_data;
      end
      axis_unfold_data <= bit_sel ? AMP : NEG_AMP;
    end
  end

endmodule

// File: tb/tb_custom_unfold_ram.sv
// Self-checking bench for custom_unfold_ram: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a word-level behavioural model.
module tb_custom_unfold_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic        ena;
  logic [31:0] axis_data;
  logic [4:0]  ADD_R;
  logic [15:0] axis_unfold_data;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the last captured word and the expected output level.
  logic [31:0] m_word;
  logic [15:0] m_out;
  logic        chk_en = 1'b0;

  custom_unfold_ram dut (
    .clk              (clk),
    .reset            (reset),
    .ena              (ena),
    .axis_data        (axis_data),
    .ADD_R            (ADD_R),
    .axis_unfold_data (axis_unfold_data)
  );

  always #5 clk = ~clk;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (axis_unfold_data !== m_out) begin
        errors++;
        $display("FAIL model_cmp t=%0t ADD_R=%0d got %h expected %h",
                 $time, ADD_R, axis_unfold_data, m_out);
      end
    end
  end

  // Apply one cycle of inputs, then advance the model at the same edge.
  task automatic step(input logic rst, input logic en,
                      input logic [31:0] data, input logic [4:0] addr);
    int unsigned pos;
    logic [31:0] src;
    @(negedge clk);
    reset = rst; ena = en; axis_data = data; ADD_R = addr;
    @(posedge clk);
    if (rst) begin
      m_word = 32'h0;
      m_out  = 16'h0000;
    end else if (en) begin
      src = (addr == 0) ? data : m_word;
`ifdef UNFOLD_MSB_FIRST_EN
      pos = 31 - int'(addr);
`else
      pos = int'(addr);
`endif
      m_out = src[pos] ? 16'h3FFF : 16'hC001;
      if (addr == 0) m_word = data;
    end
  endtask

  // Literal expectation: pins both the DUT and the model to a hand value.
  task automatic check_lit(input string name, input logic [15:0] want);
    #2;
    checks++;
    if (axis_unfold_data !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, axis_unfold_data, want);
    end
    checks++;
    if (m_out !== want) begin
      errors++;
      $display("FAIL %s_model got %h expected %h", name, m_out, want);
    end
  endtask

  logic [15:0] sweep_exp [8];
  logic [15:0] held;

  initial begin
    reset = 1'b1; ena = 1'b1; axis_data = 32'hFFFF_FFFF; ADD_R = 5'd0;

    // Reset state
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 5'd0);
    chk_en = 1'b1;
    check_lit("reset_out", 16'h0000);

`ifdef UNFOLD_MSB_FIRST_EN
    step(1'b0, 1'b1, 32'h8000_0000, 5'd0);
    check_lit("msb_idx0", 16'h3FFF);
    step(1'b0, 1'b1, $urandom, 5'd31);
    check_lit("msb_idx31", 16'hC001);
    step(1'b0, 1'b1, $urandom, 5'd1);
    check_lit("msb_idx1", 16'hC001);
`else
    step(1'b0, 1'b1, $urandom, 5'd5);
    check_lit("post_reset_idx5", 16'hC001);

    // Capture with bypass, then read from the stored word
    step(1'b0, 1'b1, 32'h0000_0001, 5'd0);
    check_lit("bypass_idx0", 16'h3FFF);
    step(1'b0, 1'b1, 32'h0000_0000, 5'd1);
    check_lit("stored_idx1", 16'hC001);

    // Full LSB-first sweep
    sweep_exp = '{16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF,
                  16'hC001, 16'hC001, 16'hC001, 16'hC001};
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, (i == 0) ? 32'hA5A5_0F0F : $urandom, 5'(i));
      if (i < 8) check_lit($sformatf("sweep_idx%0d", i), sweep_exp[i]);
      if (i == 31) check_lit("sweep_idx31", 16'h3FFF);
    end

    // Hold while disabled
    held = 16'h3FFF;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, $urandom, 5'($urandom_range(0, 31)));
    check_lit("hold_out", held);
    step(1'b0, 1'b1, $urandom, 5'd4);
    check_lit("reenable_idx4", 16'hC001);

    // Wrap-around re-captures a new word
    for (int i = 0; i < 32; i++)
      step(1'b0, 1'b1, (i == 0) ? 32'h8000_0000 : $urandom, 5'(i));
    check_lit("wrap_idx31", 16'h3FFF);
    step(1'b0, 1'b1, 32'h0000_0000, 5'd0);
    check_lit("wrap_new_idx0", 16'hC001);

    // Reset mid-word discards the captured word
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd0);
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 5'd3);
    check_lit("midword_reset", 16'h0000);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd3);
    check_lit("after_reset_idx3", 16'hC001);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), $urandom,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
